// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: definitions shared by the commit unit, the ROB and the decoder.
//   - ROB_IDX_W / XLEN defaults
//   - branch-tag encoding carried with every ROB entry
//   - commit FSM state encoding
//   - small helpers that classify a retiring entry
package commit_unit_pkg;

  localparam int ROB_IDX_W_DEF = 5;
  localparam int XLEN_DEF      = 32;

  // Entry kind tags as produced by the decoder.
  localparam logic [1:0] TAG_ALU = 2'b00;  // ALU op or load
  localparam logic [1:0] TAG_BR  = 2'b01;  // conditional branch
  localparam logic [1:0] TAG_JMP = 2'b10;  // jump (writes link register)
  localparam logic [1:0] TAG_ST  = 2'b11;  // store

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } commit_state_e;

  // A retiring entry writes the regfile only for ALU/load and jump kinds,
  // and never when the destination is x0.
  function automatic logic rf_write(input logic [1:0] tag, input logic [4:0] regaddr);
    return ((tag == TAG_ALU) || (tag == TAG_JMP)) && (regaddr != 5'd0);
  endfunction

  // Only control-flow entries can trigger a redirect; cond is meaningless
  // for the other kinds.
  function automatic logic mispredict(input logic [1:0] tag, input logic cond);
    return ((tag == TAG_BR) || (tag == TAG_JMP)) && cond;
  endfunction

endpackage

// File: rtl/commit_unit.sv
// commit_unit: retires the ROB head in program order.
//   ROB side      : commit_en_i / commit_*_i describe the head entry,
//                   commit_rdy_o pops it (combinational, same cycle).
//   Regfile side  : rf_we_o / rf_waddr_o / rf_wdata_o / rf_wid_o, one-cycle
//                   write pulse the cycle after a retire.
//   Store unit    : st_req_o / st_id_o held until st_done_i pulses.
//   Fetch / core  : flush_o (one-cycle, drives rst_c) with redirect_pc_o.
//   Stats         : retired_cnt_o counts pops, wraps modulo 2^32.
//   Control       : clk, rst_n (synchronous, active-low), rdy (global hold).
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int XLEN      = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  // ROB head
  input  logic                 commit_en_i,
  input  logic [ROB_IDX_W-1:0] commit_id_i,
  input  logic [4:0]           commit_regaddr_i,
  input  logic [XLEN-1:0]      commit_data_i,
  input  logic [XLEN-1:0]      commit_pc_i,
  input  logic [1:0]           commit_branch_tag_i,
  input  logic                 commit_cond_i,
  output logic                 commit_rdy_o,
  // register file
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic [ROB_IDX_W-1:0] rf_wid_o,
  // store unit
  output logic                 st_req_o,
  output logic [ROB_IDX_W-1:0] st_id_o,
  input  logic                 st_done_i,
  // flush / redirect
  output logic                 flush_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  // statistics
  output logic [31:0]          retired_cnt_o
);

  commit_state_e        r_state;
  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [XLEN-1:0]      r_rf_wdata;
  logic [ROB_IDX_W-1:0] r_rf_wid;
  logic                 r_st_req;
  logic [ROB_IDX_W-1:0] r_st_id;
  logic                 r_flush;
  logic [XLEN-1:0]      r_redirect_pc;
  logic [31:0]          r_retired_cnt;

  logic                 w_commit_rdy;
  logic                 w_is_store;

  assign w_is_store = (commit_branch_tag_i == TAG_ST);

  // Pop the ROB head: non-store entries retire immediately in IDLE; a store
  // retires only when the store unit reports completion. Nothing pops in
  // FLUSH since the ROB is being cleared, nor while held or in reset.
  always_comb begin
    w_commit_rdy = 1'b0;
    if (rst_n && rdy) begin
      case (r_state)
        S_IDLE:    w_commit_rdy = commit_en_i && !w_is_store;
        S_ST_WAIT: w_commit_rdy = st_done_i;
        default:   w_commit_rdy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_rf_wid      <= '0;
      r_st_req      <= 1'b0;
      r_st_id       <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_retired_cnt <= '0;
    end else if (rdy) begin
      // write-enable and flush are single-cycle pulses
      r_rf_we <= 1'b0;
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (commit_en_i) begin
            if (w_is_store) begin
              r_st_req <= 1'b1;
              r_st_id  <= commit_id_i;
              r_state  <= S_ST_WAIT;
            end else begin
              r_rf_we    <= rf_write(commit_branch_tag_i, commit_regaddr_i);
              r_rf_waddr <= commit_regaddr_i;
              r_rf_wdata <= commit_data_i;
              r_rf_wid   <= commit_id_i;
              // the link write of a mispredicted jump still happens above
              if (mispredict(commit_branch_tag_i, commit_cond_i)) begin
                r_flush       <= 1'b1;
                r_redirect_pc <= commit_pc_i;
                r_state       <= S_FLUSH;
              end
            end
          end
        end
        S_ST_WAIT: begin
          if (st_done_i) begin
            r_st_req <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit_rdy) r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign commit_rdy_o  = w_commit_rdy;
  assign rf_we_o       = r_rf_we;
  assign rf_waddr_o    = r_rf_waddr;
  assign rf_wdata_o    = r_rf_wdata;
  assign rf_wid_o      = r_rf_wid;
  assign st_req_o      = r_st_req;
  assign st_id_o       = r_st_id;
  assign flush_o       = r_flush;
  assign redirect_pc_o = r_redirect_pc;
  assign retired_cnt_o = r_retired_cnt;

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed scenarios plus a randomized run against a
// transaction-level model of the retire rules.
module tb_commit_unit;

  localparam int IW = 5;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst_n, rdy;
  logic          commit_en_i;
  logic [IW-1:0] commit_id_i;
  logic [4:0]    commit_regaddr_i;
  logic [XL-1:0] commit_data_i, commit_pc_i;
  logic [1:0]    commit_branch_tag_i;
  logic          commit_cond_i;
  logic          commit_rdy_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [XL-1:0] rf_wdata_o;
  logic [IW-1:0] rf_wid_o;
  logic          st_req_o;
  logic [IW-1:0] st_id_o;
  logic          st_done_i;
  logic          flush_o;
  logic [XL-1:0] redirect_pc_o;
  logic [31:0]   retired_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_unit #(.ROB_IDX_W(IW), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .commit_en_i(commit_en_i), .commit_id_i(commit_id_i),
    .commit_regaddr_i(commit_regaddr_i), .commit_data_i(commit_data_i),
    .commit_pc_i(commit_pc_i), .commit_branch_tag_i(commit_branch_tag_i),
    .commit_cond_i(commit_cond_i), .commit_rdy_o(commit_rdy_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_wid_o(rf_wid_o), .st_req_o(st_req_o), .st_id_o(st_id_o),
    .st_done_i(st_done_i), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .retired_cnt_o(retired_cnt_o)
  );

  // advance one clock; return 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic entry(input logic en, input logic [1:0] tag, input logic [IW-1:0] id,
                       input logic [4:0] ra, input logic [XL-1:0] d,
                       input logic [XL-1:0] pc, input logic cond);
    commit_en_i = en; commit_branch_tag_i = tag; commit_id_i = id;
    commit_regaddr_i = ra; commit_data_i = d; commit_pc_i = pc; commit_cond_i = cond;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; st_done_i = 1'b0;
    entry(1'b1, 2'b00, 5'd1, 5'd1, 32'h1, 32'h0, 1'b0);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b0) begin n_bad++; $display("FAIL reset_commit_rdy got=%0h exp=0", commit_rdy_o); end
    tick();
    n_cmp++; if (rf_we_o !== 1'b0 || st_req_o !== 1'b0 || flush_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses got we=%0h st=%0h fl=%0h exp=0", rf_we_o, st_req_o, flush_o); end
    n_cmp++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || rf_wid_o !== 5'd0 || st_id_o !== 5'd0) begin
      n_bad++; $display("FAIL reset_data got wa=%0h wd=%0h wid=%0h sid=%0h exp=0", rf_waddr_o, rf_wdata_o, rf_wid_o, st_id_o); end
    n_cmp++; if (redirect_pc_o !== 32'd0 || retired_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_pc_cnt got pc=%0h cnt=%0d exp=0", redirect_pc_o, retired_cnt_o); end
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    entry(1'b1, 2'b00, 5'd3, 5'd5, 32'h1234, 32'h0, 1'b0);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b1) begin n_bad++; $display("FAIL alu_pop got=%0h exp=1", commit_rdy_o); end
    tick();
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234 || rf_wid_o !== 5'd3) begin
      n_bad++; $display("FAIL alu_write got we=%0h wa=%0d wd=%0h wid=%0d exp 1/5/1234/3", rf_we_o, rf_waddr_o, rf_wdata_o, rf_wid_o); end
    n_cmp++; if (retired_cnt_o !== 32'd1) begin n_bad++; $display("FAIL alu_cnt got=%0d exp=1", retired_cnt_o); end
    tick();
    n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL alu_we_pulse got=%0h exp=0", rf_we_o); end
  endtask

  task automatic test_x0();
    entry(1'b1, 2'b00, 5'd4, 5'd0, 32'hdead, 32'h0, 1'b0);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b1) begin n_bad++; $display("FAIL x0_pop got=%0h exp=1", commit_rdy_o); end
    tick();
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL x0_we got=%0h exp=0", rf_we_o); end
    n_cmp++; if (retired_cnt_o !== 32'd2) begin n_bad++; $display("FAIL x0_cnt got=%0d exp=2", retired_cnt_o); end
  endtask

  task automatic test_mispred_jump();
    entry(1'b1, 2'b10, 5'd6, 5'd1, 32'h104, 32'h200, 1'b1);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b1) begin n_bad++; $display("FAIL jmp_pop got=%0h exp=1", commit_rdy_o); end
    tick();
    // a stale head is still presented; it must not pop during the flush
    entry(1'b1, 2'b00, 5'd7, 5'd2, 32'h55, 32'h0, 1'b0);
    n_cmp++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h104) begin
      n_bad++; $display("FAIL jmp_link got we=%0h wa=%0d wd=%0h exp 1/1/104", rf_we_o, rf_waddr_o, rf_wdata_o); end
    n_cmp++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
      n_bad++; $display("FAIL jmp_flush got fl=%0h pc=%0h exp 1/200", flush_o, redirect_pc_o); end
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b0) begin n_bad++; $display("FAIL jmp_flush_pop got=%0h exp=0", commit_rdy_o); end
    tick();
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (flush_o !== 1'b0 || rf_we_o !== 1'b0 || retired_cnt_o !== 32'd3) begin
      n_bad++; $display("FAIL jmp_after got fl=%0h we=%0h cnt=%0d exp 0/0/3", flush_o, rf_we_o, retired_cnt_o); end
  endtask

  task automatic test_store();
    entry(1'b1, 2'b11, 5'd7, 5'd9, 32'h77, 32'h0, 1'b0);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b0) begin n_bad++; $display("FAIL st_issue_pop got=%0h exp=0", commit_rdy_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (st_req_o !== 1'b1 || st_id_o !== 5'd7 || commit_rdy_o !== 1'b0 || rf_we_o !== 1'b0) begin
        n_bad++; $display("FAIL st_wait%0d got req=%0h id=%0d pop=%0h we=%0h exp 1/7/0/0", k, st_req_o, st_id_o, commit_rdy_o, rf_we_o); end
      tick();
    end
    st_done_i = 1'b1;
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b1 || st_req_o !== 1'b1) begin
      n_bad++; $display("FAIL st_done_pop got pop=%0h req=%0h exp 1/1", commit_rdy_o, st_req_o); end
    tick();
    st_done_i = 1'b0;
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (st_req_o !== 1'b0 || rf_we_o !== 1'b0 || retired_cnt_o !== 32'd4) begin
      n_bad++; $display("FAIL st_end got req=%0h we=%0h cnt=%0d exp 0/0/4", st_req_o, rf_we_o, retired_cnt_o); end
  endtask

  task automatic test_stall_reset();
    entry(1'b1, 2'b11, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    rdy = 1'b0; st_done_i = 1'b1;
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b0) begin n_bad++; $display("FAIL stall_pop got=%0h exp=0", commit_rdy_o); end
    tick(); tick();
    n_cmp++; if (st_req_o !== 1'b1 || st_id_o !== 5'd9 || retired_cnt_o !== 32'd4) begin
      n_bad++; $display("FAIL stall_hold got req=%0h id=%0d cnt=%0d exp 1/9/4", st_req_o, st_id_o, retired_cnt_o); end
    rdy = 1'b1; st_done_i = 1'b0; rst_n = 1'b0;
    tick();
    n_cmp++; if (st_req_o !== 1'b0 || retired_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL midstore_reset got req=%0h cnt=%0d exp 0/0", st_req_o, retired_cnt_o); end
    rst_n = 1'b1;
    st_done_i = 1'b1;
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b0) begin n_bad++; $display("FAIL idle_done_ignored got=%0h exp=0", commit_rdy_o); end
    st_done_i = 1'b0;
    entry(1'b1, 2'b00, 5'd1, 5'd1, 32'h1, 32'h0, 1'b0);
    #1;
    n_cmp++; if (commit_rdy_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle got=%0h exp=1", commit_rdy_o); end
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      entry(1'b1, 2'b00, 5'(10 + i), 5'(i + 1), 32'(32'h100 + i), 32'h0, 1'b0);
      #1;
      n_cmp++; if (commit_rdy_o !== 1'b1) begin n_bad++; $display("FAIL burst_pop%0d got=%0h exp=1", i, commit_rdy_o); end
      tick();
      n_cmp++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'(i + 1) || retired_cnt_o !== 32'(i + 1)) begin
        n_bad++; $display("FAIL burst_wr%0d got we=%0h wa=%0d cnt=%0d exp 1/%0d/%0d", i, rf_we_o, rf_waddr_o, retired_cnt_o, i + 1, i + 1); end
    end
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  // Randomized run against a model written from the retire rules:
  // "store outstanding" and "flush in progress" flags plus expected outputs.
  task automatic test_random();
    bit            store_out, flushing, pop;
    logic          e_we, e_st, e_fl;
    logic [4:0]    e_wa;
    logic [XL-1:0] e_wd, e_pc;
    logic [IW-1:0] e_wid, e_sid;
    logic [31:0]   e_cnt;
    int            bad_before;
    rst_n = 1'b0; rdy = 1'b1; st_done_i = 1'b0;
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    store_out = 0; flushing = 0;
    e_we = 0; e_st = 0; e_fl = 0; e_wa = 0; e_wd = 0; e_pc = 0; e_wid = 0; e_sid = 0; e_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      rdy   = ($urandom_range(0, 7) != 0);
      st_done_i = ($urandom_range(0, 2) == 0);
      entry($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
            $urandom_range(0, 1) == 1);
      #1;
      if (!rst_n || !rdy || flushing) pop = 0;
      else if (store_out)              pop = st_done_i;
      else                             pop = commit_en_i && commit_branch_tag_i != 2'b11;
      n_cmp++; if (commit_rdy_o !== pop) begin n_bad++; $display("FAIL rnd_pop c=%0d got=%0h exp=%0h", c, commit_rdy_o, pop); end
      if (!rst_n) begin
        store_out = 0; flushing = 0;
        e_we = 0; e_st = 0; e_fl = 0; e_wa = 0; e_wd = 0; e_pc = 0; e_wid = 0; e_sid = 0; e_cnt = 0;
      end else if (rdy) begin
        e_we = 0; e_fl = 0;
        if (pop) e_cnt++;
        if (flushing) flushing = 0;
        else if (store_out) begin
          if (st_done_i) begin store_out = 0; e_st = 0; end
        end else if (commit_en_i) begin
          if (commit_branch_tag_i == 2'b11) begin
            store_out = 1; e_st = 1; e_sid = commit_id_i;
          end else begin
            e_we  = (commit_branch_tag_i != 2'b01) && (commit_regaddr_i != 0);
            e_wa  = commit_regaddr_i; e_wd = commit_data_i; e_wid = commit_id_i;
            if (commit_branch_tag_i != 2'b00 && commit_cond_i) begin
              e_fl = 1; e_pc = commit_pc_i; flushing = 1;
            end
          end
        end
      end
      tick();
      bad_before = n_bad;
      n_cmp++; if (rf_we_o !== e_we || rf_waddr_o !== e_wa || rf_wdata_o !== e_wd || rf_wid_o !== e_wid) begin
        n_bad++; $display("FAIL rnd_rf c=%0d got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h", c, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wid_o, e_we, e_wa, e_wd, e_wid); end
      n_cmp++; if (st_req_o !== e_st || st_id_o !== e_sid) begin
        n_bad++; $display("FAIL rnd_st c=%0d got %0h/%0h exp %0h/%0h", c, st_req_o, st_id_o, e_st, e_sid); end
      n_cmp++; if (flush_o !== e_fl || redirect_pc_o !== e_pc) begin
        n_bad++; $display("FAIL rnd_flush c=%0d got %0h/%0h exp %0h/%0h", c, flush_o, redirect_pc_o, e_fl, e_pc); end
      n_cmp++; if (retired_cnt_o !== e_cnt) begin
        n_bad++; $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, retired_cnt_o, e_cnt); end
      if (n_bad > bad_before + 0 && n_bad > 20) break;
    end
    rst_n = 1'b1; rdy = 1'b1; st_done_i = 1'b0;
    entry(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_x0();
    test_mispred_jump();
    test_store();
    test_stall_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
